// File: rtl/timer_pkg.sv
// Shared state encodings and parameter defaults for the timer trigger controller.
package timer_pkg;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REQ      = 2'd1;
    localparam logic [1:0] S_WAIT_ACK = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    localparam int unsigned CNT_W_DEF        = 16;
    localparam logic [31:0] TIMEOUT_CLKS_DEF = 32'd10000;

endpackage

// File: rtl/trig_pulse_gen.sv
// Retriggerable pulse stretcher: each fire yields PULSE_W high clocks, restarting if already high.
module trig_pulse_gen #(
    parameter int unsigned PULSE_W = 4
) (
    input  logic I_Clk,
    input  logic I_rst,
    input  logic I_fire,
    output logic O_trig
);

    localparam int unsigned CW = $clog2(PULSE_W + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          trig_q, trig_d;

    always_comb begin
        cnt_d = cnt_q;
        if (I_fire) begin
            cnt_d = CW'(PULSE_W);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        trig_d = (cnt_d != '0);
    end

    always_ff @(posedge I_Clk) begin
        if (I_rst) begin
            cnt_q  <= '0;
            trig_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            trig_q <= trig_d;
        end
    end

    assign O_trig = trig_q;

endmodule

// File: rtl/timer_trig_ctrl.sv
// Drives request pulses into the microsecond timer, turns each ack into an indexed trigger
// pulse, and ends a run with a done pulse or a sticky timeout flag.
module timer_trig_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned PULSE_W      = 4,
    parameter logic [31:0] TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
    input  logic             I_Clk,
    input  logic             I_rst,
    input  logic             I_start,
    input  logic             I_stop,
    input  logic [CNT_W-1:0] I_num_periods,
    output logic             O_tmr_req,
    input  logic             I_tmr_busy,
    input  logic             I_tmr_ack,
    output logic             O_trig,
    output logic [CNT_W-1:0] O_trig_idx,
    output logic             O_running,
    output logic             O_done,
    output logic             O_err_timeout
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [31:0]      tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             running_q, running_d;
    logic             fire;

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        req_d   = 1'b0;
        fire    = 1'b0;

        if (I_stop) begin
            // Stop beats start and ack alike: no trigger, no count, no done.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (I_start) begin
                        num_d   = I_num_periods;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_REQ;
                    end
                end
                S_REQ: state_d = S_REQ;
                S_WAIT_ACK: begin
                    if (I_tmr_ack) begin
                        fire    = 1'b1;
                        idx_d   = cnt_q;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = (num_q != '0 && cnt_d == num_q) ? S_DONE : S_REQ;
                    end else if (TIMEOUT_CLKS != 32'd0 && tmo_q >= TIMEOUT_CLKS - 32'd1) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (tmo_q != '1) begin
                        tmo_d = tmo_q + 32'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // A pending request goes out on the same edge that decided it, if the timer is free.
            if (state_d == S_REQ && !I_tmr_busy) begin
                req_d   = 1'b1;
                tmo_d   = '0;
                state_d = S_WAIT_ACK;
            end
        end

        done_d    = (state_d == S_DONE);
        running_d = (state_d == S_REQ) || (state_d == S_WAIT_ACK);
    end

    always_ff @(posedge I_Clk) begin
        if (I_rst) begin
            state_q   <= S_IDLE;
            num_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            req_q     <= req_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    trig_pulse_gen #(
        .PULSE_W (PULSE_W)
    ) u_pulse (
        .I_Clk  (I_Clk),
        .I_rst  (I_rst),
        .I_fire (fire),
        .O_trig (O_trig)
    );

    assign O_tmr_req     = req_q;
    assign O_trig_idx    = idx_q;
    assign O_running     = running_q;
    assign O_done        = done_q;
    assign O_err_timeout = err_q;

endmodule

// File: tb/tb_timer_trig_ctrl.sv
// Randomised and directed bench for timer_trig_ctrl against an event-level model of a run.
module tb_timer_trig_ctrl;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned PULSE_W = 4;
    localparam int unsigned TMO     = 50;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic tb_busy = 1'b0, tb_ack = 1'b0, emu_busy = 1'b0, emu_ack = 1'b0;
    logic [CNT_W-1:0] num = '0;
    logic tmr_busy, tmr_ack;
    logic dut_req, dut_trig, dut_running, dut_done, dut_err;
    logic [CNT_W-1:0] dut_idx;

    assign tmr_busy = tb_busy | emu_busy;
    assign tmr_ack  = tb_ack | emu_ack;

    always #5 clk = ~clk;

    timer_trig_ctrl #(
        .CNT_W        (CNT_W),
        .PULSE_W      (PULSE_W),
        .TIMEOUT_CLKS (32'(TMO))
    ) dut (
        .I_Clk         (clk),
        .I_rst         (rst),
        .I_start       (start),
        .I_stop        (stop),
        .I_num_periods (num),
        .O_tmr_req     (dut_req),
        .I_tmr_busy    (tmr_busy),
        .I_tmr_ack     (tmr_ack),
        .O_trig        (dut_trig),
        .O_trig_idx    (dut_idx),
        .O_running     (dut_running),
        .O_done        (dut_done),
        .O_err_timeout (dut_err)
    );

    // Timer stand-in: goes busy on a request and acks after a delay.
    int emu_cnt = 0;
    int emu_delay = 20;
    bit emu_on = 1'b0, emu_rand = 1'b0, emu_will_ack = 1'b0;

    always @(negedge clk) begin
        emu_ack = 1'b0;
        if (emu_cnt != 0) begin
            emu_cnt = emu_cnt - 1;
            if (emu_cnt == 0) begin
                emu_busy = 1'b0;
                emu_ack  = emu_will_ack;
            end
        end else if (emu_on && dut_req) begin
            emu_busy     = 1'b1;
            emu_cnt      = emu_rand ? int'($urandom_range(1, 8)) : emu_delay;
            emu_will_ack = emu_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
        end
    end

    // Reference model: a run is "active", has a request either pending or outstanding,
    // and a trigger pulse has some number of clocks left.
    bit m_active = 0, m_pending = 0, m_outstanding = 0, m_done_prev = 0;
    int m_waited = 0, m_count = 0, m_left = 0, m_num = 0;
    bit e_req = 0, e_trig = 0, e_running = 0, e_done = 0, e_err = 0;
    int e_idx = 0;

    always @(posedge clk) begin
        m_done_prev = e_done;
        e_req  = 1'b0;
        e_done = 1'b0;
        if (m_left > 0) m_left = m_left - 1;
        if (rst) begin
            m_active = 0; m_pending = 0; m_outstanding = 0;
            m_count = 0; m_left = 0; e_idx = 0; e_err = 0;
        end else begin
            if (stop) begin
                m_active = 0;
            end else if (!m_active) begin
                if (start && !m_done_prev) begin
                    m_active = 1; m_num = int'(num); m_count = 0; e_err = 0;
                    m_pending = 1; m_outstanding = 0;
                end
            end else if (m_outstanding) begin
                if (tmr_ack) begin
                    m_left = PULSE_W;
                    e_idx = m_count % (1 << CNT_W);
                    m_count = m_count + 1;
                    m_outstanding = 0;
                    if (m_num != 0 && m_count == m_num) begin
                        m_active = 0; e_done = 1;
                    end else begin
                        m_pending = 1;
                    end
                end else begin
                    m_waited = m_waited + 1;
                    if (TMO != 0 && m_waited >= TMO) begin
                        e_err = 1; m_active = 0; e_done = 1;
                    end
                end
            end
            if (m_active && m_pending && !tmr_busy) begin
                e_req = 1; m_pending = 0; m_outstanding = 1; m_waited = 0;
            end
        end
        e_running = m_active;
        e_trig    = (m_left > 0);
    end

    int n_checks = 0, n_errors = 0, cyc = 0;
    int n_req = 0, n_done = 0, n_rise = 0, n_hi = 0;
    int req_cyc = 0, done_cyc = 0, rise_cyc = 0;
    int idx_log[$];
    bit chk_en = 1'b0, trig_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance one clock, sample #1 after the edge, compare against the model.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (chk_en) begin
                check("tmr_req", 32'(dut_req), 32'(e_req));
                check("trig", 32'(dut_trig), 32'(e_trig));
                check("trig_idx", 32'(dut_idx), 32'(e_idx));
                check("running", 32'(dut_running), 32'(e_running));
                check("done", 32'(dut_done), 32'(e_done));
                check("err_timeout", 32'(dut_err), 32'(e_err));
                if (dut_req) begin n_req++; req_cyc = cyc; end
                if (dut_done) begin n_done++; done_cyc = cyc; end
                if (dut_trig) n_hi++;
                if (dut_trig && !trig_prev) begin
                    n_rise++; rise_cyc = cyc; idx_log.push_back(int'(dut_idx));
                end
                trig_prev = dut_trig;
            end
        end
    endtask

    task automatic wait_done(input int base, input int budget, input string what);
        int t = 0;
        while (n_done == base && t < budget) begin step(1); t++; end
        if (n_done == base) begin
            n_checks++; n_errors++;
            $display("FAIL %s: no done pulse within %0d cycles", what, budget);
        end
    endtask

    task automatic wait_rises(input int target, input int budget, input string what);
        int t = 0;
        while (n_rise < target && t < budget) begin step(1); t++; end
        if (n_rise < target) begin
            n_checks++; n_errors++;
            $display("FAIL %s: got %0d triggers expected %0d", what, n_rise, target);
        end
    endtask

    initial begin
        int b_req, b_done, b_rise, b_hi, sz;

        step(3);
        chk_en = 1'b1;
        check("rst_req", 32'(dut_req), 32'd0);
        check("rst_trig", 32'(dut_trig), 32'd0);
        check("rst_idx", 32'(dut_idx), 32'd0);
        check("rst_running", 32'(dut_running), 32'd0);
        check("rst_done", 32'(dut_done), 32'd0);
        check("rst_err", 32'(dut_err), 32'd0);
        rst = 1'b0;
        step(2);

        // N=3, acks 20 clocks after each request.
        emu_on = 1; emu_rand = 0; emu_delay = 20;
        b_req = n_req; b_done = n_done; b_rise = n_rise; b_hi = n_hi;
        num = 4'd3; start = 1'b1; step(1); start = 1'b0;
        check("s1_first_req", 32'(dut_req), 32'd1);
        check("s1_running", 32'(dut_running), 32'd1);
        wait_done(b_done, 300, "s1_done_wait");
        step(6);
        check("s1_req_count", n_req - b_req, 32'd3);
        check("s1_trig_count", n_rise - b_rise, 32'd3);
        check("s1_done_count", n_done - b_done, 32'd1);
        check("s1_trig_clocks", n_hi - b_hi, 32'd12);
        sz = idx_log.size();
        check("s1_idx_a", idx_log[sz-3], 32'd0);
        check("s1_idx_b", idx_log[sz-2], 32'd1);
        check("s1_idx_c", idx_log[sz-1], 32'd2);
        check("s1_done_with_trig", done_cyc, rise_cyc);
        check("s1_idle_after", 32'(dut_running), 32'd0);

        // N=0: five periods then stop; the in-flight ack later arrives while idle.
        b_done = n_done; b_rise = n_rise;
        num = 4'd0; start = 1'b1; step(1); start = 1'b0;
        wait_rises(b_rise + 5, 400, "s2_five_triggers");
        stop = 1'b1; step(1); stop = 1'b0;
        check("s2_running_drop", 32'(dut_running), 32'd0);
        step(40);
        check("s2_trig_count", n_rise - b_rise, 32'd5);
        check("s2_no_done", n_done - b_done, 32'd0);

        // Busy held for 10 clocks, then a request, then no ack so it times out.
        emu_on = 0; tb_busy = 1'b1;
        b_req = n_req; b_done = n_done;
        num = 4'd1; start = 1'b1; step(1); start = 1'b0;
        step(10);
        check("s3_no_req_while_busy", n_req - b_req, 32'd0);
        check("s3_running", 32'(dut_running), 32'd1);
        tb_busy = 1'b0; step(1);
        check("s3_req_after_busy", 32'(dut_req), 32'd1);
        step(1);
        check("s3_req_one_cycle", 32'(dut_req), 32'd0);
        wait_done(b_done, 100, "s4_timeout_wait");
        check("s4_timeout_gap", done_cyc - req_cyc, 32'd50);
        check("s4_err_set", 32'(dut_err), 32'd1);
        step(3);
        check("s4_err_sticky", 32'(dut_err), 32'd1);
        check("s4_idle", 32'(dut_running), 32'd0);
        emu_on = 1; emu_delay = 3; b_done = n_done;
        num = 4'd1; start = 1'b1; step(1); start = 1'b0;
        check("s4_err_cleared", 32'(dut_err), 32'd0);
        wait_done(b_done, 100, "s4_rerun_wait");
        step(6);

        // Retrigger: acks 3 clocks apart keep the 4-clock pulse continuously high.
        emu_on = 0; b_rise = n_rise; b_hi = n_hi;
        num = 4'd0; start = 1'b1; step(1); start = 1'b0;
        step(2);
        for (int i = 0; i < 4; i++) begin
            tb_ack = 1'b1; step(1); tb_ack = 1'b0; step(2);
        end
        step(8);
        check("s5_single_rise", n_rise - b_rise, 32'd1);
        check("s5_high_clocks", n_hi - b_hi, 32'd13);
        check("s5_last_idx", 32'(dut_idx), 32'd3);
        stop = 1'b1; step(1); stop = 1'b0; step(2);

        // Reset mid-pulse after two acks of an N=4 run.
        emu_on = 1; emu_delay = 5; b_rise = n_rise; b_done = n_done;
        num = 4'd4; start = 1'b1; step(1); start = 1'b0;
        wait_rises(b_rise + 2, 100, "s6_two_triggers");
        rst = 1'b1; step(1); rst = 1'b0;
        check("s6_trig_low", 32'(dut_trig), 32'd0);
        check("s6_req_low", 32'(dut_req), 32'd0);
        check("s6_running_low", 32'(dut_running), 32'd0);
        check("s6_idx_zero", 32'(dut_idx), 32'd0);
        step(20);
        check("s6_no_done", n_done - b_done, 32'd0);
        sz = idx_log.size(); b_done = n_done;
        num = 4'd2; start = 1'b1; step(1); start = 1'b0;
        wait_done(b_done, 100, "s6_restart_wait");
        step(6);
        check("s6_restart_idx_a", idx_log[sz], 32'd0);
        check("s6_restart_idx_b", idx_log[sz+1], 32'd1);

        // Random traffic against the model.
        emu_rand = 1; emu_on = 1;
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 399) == 0);
            start   = ($urandom_range(0, 14) == 0);
            stop    = ($urandom_range(0, 79) == 0);
            num     = CNT_W'($urandom_range(0, 5));
            tb_busy = ($urandom_range(0, 5) == 0);
            tb_ack  = ($urandom_range(0, 59) == 0);
            step(1);
        end
        rst = 0; start = 0; stop = 0; tb_busy = 0; tb_ack = 0;
        step(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
